// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer in front of the 32-bit ALU: accepts one op, drives the
// one-hot ALU select for the op's latency, then holds ZHI/ZLO until consumed.
module alu_op_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  opcode,
  input  logic [31:0] ra_in,
  input  logic [31:0] rb_in,
  output logic [11:0] alu_sel,
  output logic [31:0] alu_ra,
  output logic [31:0] alu_rb,
  input  logic [31:0] alu_zhi,
  input  logic [31:0] alu_zlo,
  output logic [31:0] zhi_out,
  output logic [31:0] zlo_out,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        illegal_op,
  output logic        div_zero,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [3:0]      op_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_load;
  logic            dz_q;
  logic            accept;
  logic            op_legal;
  logic            new_dz;
  logic            exec_done;

  // Handshakes: a request transfers on a rising edge where op_valid && op_ready;
  // a result transfers on a rising edge where result_valid && result_ready.
  assign accept    = (state == IDLE) && op_valid;
  assign op_legal  = (opcode < 4'd12);
  assign new_dz    = (opcode == 4'd9) && (rb_in == 32'd0);
  assign exec_done = (state == EXEC) && (cnt == '0);

  always_comb begin
    cnt_load = '0;
    if (opcode == 4'd8)
      cnt_load = CW'(MUL_CYCLES - 1);
    else if ((opcode == 4'd9) && !new_dz)
      cnt_load = CW'(DIV_CYCLES - 1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && op_legal) state_next = EXEC;
      EXEC:    if (cnt == '0)          state_next = DONE;
      DONE:    if (result_ready)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      op_q       <= '0;
      cnt        <= '0;
      dz_q       <= 1'b0;
      alu_ra     <= '0;
      alu_rb     <= '0;
      zhi_out    <= '0;
      zlo_out    <= '0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_next;
      illegal_op <= accept && !op_legal;
      if (accept) begin
        op_q   <= opcode;
        alu_ra <= ra_in;
        alu_rb <= rb_in;
        cnt    <= cnt_load;
        dz_q   <= new_dz;
      end else if ((state == EXEC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      // Divide by zero bypasses the ALU: quotient saturates, dividend returned as remainder.
      if (exec_done) begin
        if (dz_q) begin
          zhi_out <= alu_ra;
          zlo_out <= 32'hFFFF_FFFF;
        end else begin
          zhi_out <= alu_zhi;
          zlo_out <= alu_zlo;
        end
      end
    end
  end

  assign op_ready     = (state == IDLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign div_zero     = (state == DONE) && dz_q;
  assign alu_sel      = ((state == EXEC) && !dz_q) ? (12'd1 << op_q) : 12'd0;
  assign fsm_state    = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and an expected
// result queue checked when each result appears.
module tb_alu_op_sequencer;

  logic        clock;
  logic        clear;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  opcode;
  logic [31:0] ra_in, rb_in;
  logic [11:0] alu_sel;
  logic [31:0] alu_ra, alu_rb;
  logic [31:0] alu_zhi, alu_zlo;
  logic [31:0] zhi_out, zlo_out;
  logic        result_valid;
  logic        result_ready;
  logic        illegal_op;
  logic        div_zero;
  logic        busy;
  logic [1:0]  fsm_state;

  logic [63:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  alu_op_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
    .clock        (clock),
    .clear        (clear),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .opcode       (opcode),
    .ra_in        (ra_in),
    .rb_in        (rb_in),
    .alu_sel      (alu_sel),
    .alu_ra       (alu_ra),
    .alu_rb       (alu_rb),
    .alu_zhi      (alu_zhi),
    .alu_zlo      (alu_zlo),
    .zhi_out      (zhi_out),
    .zlo_out      (zlo_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .illegal_op   (illegal_op),
    .div_zero     (div_zero),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural ALU driven by the one-hot select
  logic [63:0] prod;
  assign prod = {32'd0, alu_ra} * {32'd0, alu_rb};
  always_comb begin
    alu_zhi = 32'd0;
    alu_zlo = 32'd0;
    case (alu_sel)
      12'h001: alu_zlo = alu_ra + alu_rb;
      12'h002: alu_zlo = alu_ra - alu_rb;
      12'h040: alu_zlo = alu_ra & alu_rb;
      12'h080: alu_zlo = alu_ra | alu_rb;
      12'h100: {alu_zhi, alu_zlo} = prod;
      12'h200: if (alu_rb != 32'd0) begin
                 alu_zlo = alu_ra / alu_rb;
                 alu_zhi = alu_ra % alu_rb;
               end
      12'h400: alu_zlo = -alu_ra;
      12'h800: alu_zlo = ~alu_ra;
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic start_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    exp_q.push_back(exp);
    opcode   = opc;
    ra_in    = a;
    rb_in    = b;
    op_valid = 1'b1;
    chk("op_ready_pre", 64'(op_ready), 64'd1);
    step();
    op_valid = 1'b0;
    chk("busy_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_result(input string tag, input int lat, input logic [11:0] sel_exp);
    int n;
    logic [63:0] e;
    n = 0;
    while (!result_valid && n < 64) begin
      chk({tag, "_sel"}, 64'(alu_sel), 64'(sel_exp));
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_rv"}, 64'(result_valid), 64'd1);
    chk({tag, "_sel_done"}, 64'(alu_sel), 64'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk({tag, "_res"}, {zhi_out, zlo_out}, e);
  endtask

  task automatic finish_op(input string tag);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_rv_drop"}, 64'(result_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(op_ready), 64'd1);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    clear        = 1'b1;
    op_valid     = 1'b0;
    opcode       = 4'd0;
    ra_in        = 32'd0;
    rb_in        = 32'd0;
    result_ready = 1'b0;

    #12;
    chk("rst_sel", 64'(alu_sel), 64'd0);
    chk("rst_zlo", 64'(zlo_out), 64'd0);
    chk("rst_zhi", 64'(zhi_out), 64'd0);
    chk("rst_ra", 64'(alu_ra), 64'd0);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_ill", 64'(illegal_op), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    step();
    chk("rst_ready", 64'(op_ready), 64'd1);

    // add 5+7
    start_op(4'd0, 32'd5, 32'd7, {32'd0, 32'd12});
    wait_result("add", 1, 12'h001);
    finish_op("add");

    // multiply 2^16 * 2^16
    start_op(4'd8, 32'h10000, 32'h10000, {32'd1, 32'd0});
    wait_result("mul", 4, 12'h100);
    finish_op("mul");

    // divide by zero
    start_op(4'd9, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
    wait_result("dz", 1, 12'h000);
    chk("dz_flag", 64'(div_zero), 64'd1);
    finish_op("dz");
    chk("dz_flag_drop", 64'(div_zero), 64'd0);

    // normal divide 100/7
    start_op(4'd9, 32'd100, 32'd7, {32'd2, 32'd14});
    wait_result("div", 8, 12'h200);
    chk("div_nodz", 64'(div_zero), 64'd0);
    finish_op("div");

    // random logic/unary ops
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom_range(32'hFFFF, 0);
      start_op(4'd6, a, b, {32'd0, a & b});
      wait_result("and", 1, 12'h040);
      finish_op("and");
      start_op(4'd7, a, b, {32'd0, a | b});
      wait_result("or", 1, 12'h080);
      finish_op("or");
      start_op(4'd10, a, b, {32'd0, 32'd0 - a});
      wait_result("neg", 1, 12'h400);
      finish_op("neg");
      start_op(4'd11, a, b, {32'd0, ~a});
      wait_result("not", 1, 12'h800);
      finish_op("not");
    end

    // backpressure with a concurrent request held
    start_op(4'd1, 32'd9, 32'd3, {32'd0, 32'd6});
    wait_result("sub", 1, 12'h002);
    op_valid = 1'b1;
    opcode   = 4'd0;
    ra_in    = 32'd2;
    rb_in    = 32'd2;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rv", 64'(result_valid), 64'd1);
      chk("bp_zlo", 64'(zlo_out), 64'd6);
      chk("bp_ready", 64'(op_ready), 64'd0);
      chk("bp_ra_hold", 64'(alu_ra), 64'd9);
      step();
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("bp_idle", 64'(busy), 64'd0);
    chk("bp_not_taken", 64'(alu_ra), 64'd9);
    exp_q.push_back({32'd0, 32'd4});
    step();
    op_valid = 1'b0;
    chk("bp_taken", 64'(busy), 64'd1);
    chk("bp_ra_new", 64'(alu_ra), 64'd2);
    wait_result("bp_add", 1, 12'h001);
    finish_op("bp_add");

    // illegal opcodes, including back-to-back
    op_valid = 1'b1;
    opcode   = 4'd14;
    step();
    chk("ill_pulse", 64'(illegal_op), 64'd1);
    chk("ill_ready", 64'(op_ready), 64'd1);
    chk("ill_busy", 64'(busy), 64'd0);
    chk("ill_rv", 64'(result_valid), 64'd0);
    opcode = 4'd12;
    step();
    chk("ill_b2b_a", 64'(illegal_op), 64'd1);
    opcode = 4'd15;
    step();
    chk("ill_b2b_b", 64'(illegal_op), 64'd1);
    op_valid = 1'b0;
    step();
    chk("ill_drop", 64'(illegal_op), 64'd0);
    chk("ill_no_rv", 64'(result_valid), 64'd0);

    // reset in the middle of a divide
    start_op(4'd9, 32'd50, 32'd5, {32'd0, 32'd10});
    step();
    step();
    clear = 1'b1;
    #1;
    chk("abort_sel", 64'(alu_sel), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rv", 64'(result_valid), 64'd0);
    chk("abort_ra", 64'(alu_ra), 64'd0);
    chk("abort_rb", 64'(alu_rb), 64'd0);
    chk("abort_zlo", 64'(zlo_out), 64'd0);
    chk("abort_zhi", 64'(zhi_out), 64'd0);
    exp_q.delete();
    @(negedge clock);
    clear = 1'b0;
    step();
    chk("abort_ready", 64'(op_ready), 64'd1);
    start_op(4'd0, 32'd1, 32'd1, {32'd0, 32'd2});
    wait_result("post_rst", 1, 12'h001);
    finish_op("post_rst");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
